// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data-access and byte-wide RAM signals around the memory arbiter.
// No logic and no latency; it only carries signals.
// The requesters hold their request until the matching done pulse, and the RAM accepts every cycle.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    // instruction fetch requester
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [31:0]       if_data_o;
    logic              if_done_o;

    // data-access requester
    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_width_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_done_o;

    // branch redirect
    logic              flush_i;

    // byte-wide synchronous RAM port
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_we_o;
    logic [7:0]        ram_wdata_o;
    logic [7:0]        ram_rdata_i;

    // stall requests to the pipeline controller
    logic              stall_req_if_o;
    logic              stall_req_mem_o;

    // arbiter side
    modport slave (
        input  if_req_i, if_addr_i,
        output if_data_o, if_done_o,
        input  mem_req_i, mem_we_i, mem_width_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_done_o,
        input  flush_i,
        output ram_addr_o, ram_we_o, ram_wdata_o,
        input  ram_rdata_i,
        output stall_req_if_o, stall_req_mem_o
    );

    // requester / RAM side
    modport master (
        output if_req_i, if_addr_i,
        input  if_data_o, if_done_o,
        output mem_req_i, mem_we_i, mem_width_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_done_o,
        output flush_i,
        input  ram_addr_o, ram_we_o, ram_wdata_o,
        output ram_rdata_i,
        input  stall_req_if_o, stall_req_mem_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and data access, packing and unpacking little-endian words.
// A read completes at A+n+2 and a write at A+n+1, where A is the acceptance cycle and n is 1, 2 or 4 bytes.
// A request is held until its done pulse, MEM wins over IF, and a flush kills an in-flight fetch.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_IF  = 2'd1;
    localparam logic [1:0] BUSY_MEM = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [2:0]        cyc_q,       cyc_d;
    logic [2:0]        nbytes_q,    nbytes_d;
    logic [ADDR_W-1:0] base_q,      base_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic              we_q,        we_d;
    logic [31:0]       asm_q,       asm_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic              ram_we_q,    ram_we_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic [31:0]       if_data_q,   if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              mem_done_q,  mem_done_d;

    logic [2:0]        cyc_nxt;
    logic [1:0]        rd_idx;
    logic [2:0]        mem_nbytes;

    // Byte count of a data access; an encoding of 3 is handled as a word.
    always_comb begin
        mem_nbytes = 3'd4;
        case (bus.mem_width_i)
            2'd0:    mem_nbytes = 3'd1;
            2'd1:    mem_nbytes = 3'd2;
            default: mem_nbytes = 3'd4;
        endcase
    end

    // Scheduler. cyc_q counts the busy cycles: in cycle j the address of byte j is on the RAM
    // port, and the read data for byte j-1 is on ram_rdata_i.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        asm_d       = asm_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        cyc_nxt     = cyc_q + 3'd1;
        rd_idx      = cyc_q[1:0] - 2'd1;

        case (state_q)
            IDLE: begin
                // A request still held while its own done pulse is high is not accepted again.
                if (!(if_done_q || mem_done_q)) begin
                    if (bus.mem_req_i) begin
                        state_d     = BUSY_MEM;
                        cyc_d       = 3'd0;
                        nbytes_d    = mem_nbytes;
                        base_d      = bus.mem_addr_i;
                        wdata_d     = bus.mem_wdata_i;
                        we_d        = bus.mem_we_i;
                        asm_d       = 32'h0;
                        ram_addr_d  = bus.mem_addr_i;
                        ram_we_d    = bus.mem_we_i;
                        ram_wdata_d = bus.mem_wdata_i[7:0];
                    end else if (bus.if_req_i && !bus.flush_i) begin
                        state_d     = BUSY_IF;
                        cyc_d       = 3'd0;
                        nbytes_d    = 3'd4;
                        base_d      = bus.if_addr_i;
                        wdata_d     = 32'h0;
                        we_d        = 1'b0;
                        asm_d       = 32'h0;
                        ram_addr_d  = bus.if_addr_i;
                        ram_we_d    = 1'b0;
                    end
                end
            end

            BUSY_IF, BUSY_MEM: begin
                if (state_q == BUSY_IF && bus.flush_i) begin
                    // The redirected fetch starts over from byte 0, and the old fetch leaves no trace.
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_nxt;
                    if (cyc_nxt < nbytes_q) begin
                        ram_addr_d  = base_q + ADDR_W'(cyc_nxt);
                        ram_we_d    = we_q;
                        ram_wdata_d = wdata_q[{cyc_nxt[1:0], 3'b000} +: 8];
                    end
                    if (we_q) begin
                        // A write is done once its last byte has been on the port.
                        if (cyc_nxt == nbytes_q) begin
                            mem_done_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end else begin
                        if (cyc_q != 3'd0) begin
                            asm_d[{rd_idx, 3'b000} +: 8] = bus.ram_rdata_i;
                        end
                        // The last byte arrives the cycle after its address and is captured directly.
                        if (cyc_q == nbytes_q) begin
                            state_d = IDLE;
                            if (state_q == BUSY_IF) begin
                                if_data_d = asm_d;
                                if_done_d = 1'b1;
                            end else begin
                                mem_rdata_d = asm_d;
                                mem_done_d  = 1'b1;
                            end
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset drops ram_we_o at once and clears every output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cyc_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            asm_q       <= 32'h0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 8'h0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            asm_q       <= asm_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign bus.ram_addr_o      = ram_addr_q;
    assign bus.ram_we_o        = ram_we_q;
    assign bus.ram_wdata_o     = ram_wdata_q;
    assign bus.if_data_o       = if_data_q;
    assign bus.if_done_o       = if_done_q;
    assign bus.mem_rdata_o     = mem_rdata_q;
    assign bus.mem_done_o      = mem_done_q;
    assign bus.stall_req_if_o  = bus.if_req_i  & ~if_done_q;
    assign bus.stall_req_mem_o = bus.mem_req_i & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized transactions against a byte-array memory model.
// Outputs are sampled on the falling edge, and inputs change on the falling edge.
// Requests are held until the matching done pulse and dropped in that same cycle.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  ram    [0:4095];
    logic [7:0]  shadow [0:4095];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_if_data   = 32'h0;
    logic [31:0] exp_mem_data  = 32'h0;
    logic [31:0] exp_last_addr = 32'h0;

    // Synchronous byte RAM: read data is valid the cycle after the address.
    always @(posedge clk) begin
        if (bus.ram_we_o) ram[bus.ram_addr_o[11:0]] <= bus.ram_wdata_o;
        bus.ram_rdata_i <= ram[bus.ram_addr_o[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_byte(input logic [11:0] a, input logic [7:0] v);
        ram[a]    = v;
        shadow[a] = v;
    endtask

    // Quiet cycles: no RAM write, no done pulse, address and data held.
    task automatic idle(input int m);
        for (int c = 0; c < m; c++) begin
            @(negedge clk);
            check("idle_we",       {31'h0, bus.ram_we_o},   32'h0);
            check("idle_if_done",  {31'h0, bus.if_done_o},  32'h0);
            check("idle_mem_done", {31'h0, bus.mem_done_o}, 32'h0);
            check("idle_addr",     bus.ram_addr_o, exp_last_addr);
            check("if_data_hold",  bus.if_data_o,  exp_if_data);
            check("mem_data_hold", bus.mem_rdata_o, exp_mem_data);
            check("idle_stall_if",  {31'h0, bus.stall_req_if_o},  {31'h0, bus.if_req_i});
            check("idle_stall_mem", {31'h0, bus.stall_req_mem_o}, {31'h0, bus.mem_req_i});
        end
    endtask

    // One transaction, started right after a falling edge so that this cycle is the acceptance cycle.
    task automatic run_txn(input bit is_if, input bit we, input logic [1:0] width,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        int          dk;
        bit          wr;
        bit          e_ifd;
        bit          e_memd;
        logic [31:0] rd;
        logic [11:0] a;
        n  = is_if ? 4 : (width == 2'd0 ? 1 : (width == 2'd1 ? 2 : 4));
        wr = !is_if && we;
        dk = wr ? n + 1 : n + 2;
        rd = 32'h0;
        for (int i = 0; i < n; i++) begin
            a = addr[11:0] + 12'(i);
            if (wr) shadow[a] = wdata[8*i +: 8];
            else    rd[8*i +: 8] = shadow[a];
        end
        if (is_if) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = addr;
        end else begin
            bus.mem_req_i   = 1'b1;
            bus.mem_we_i    = we;
            bus.mem_width_i = width;
            bus.mem_addr_i  = addr;
            bus.mem_wdata_i = wdata;
        end
        for (int k = 1; k <= dk; k++) begin
            @(negedge clk);
            e_ifd  = is_if && (k == dk);
            e_memd = !is_if && (k == dk);
            if (k <= n) begin
                check("ram_addr", bus.ram_addr_o, addr + 32'(k - 1));
                check("ram_we", {31'h0, bus.ram_we_o}, {31'h0, wr});
                if (wr) check("ram_wdata", {24'h0, bus.ram_wdata_o}, {24'h0, wdata[8*(k-1) +: 8]});
            end else begin
                check("ram_we_off", {31'h0, bus.ram_we_o}, 32'h0);
            end
            check("if_done",   {31'h0, bus.if_done_o},  {31'h0, e_ifd});
            check("mem_done",  {31'h0, bus.mem_done_o}, {31'h0, e_memd});
            check("stall_if",  {31'h0, bus.stall_req_if_o},  {31'h0, bus.if_req_i  && !e_ifd});
            check("stall_mem", {31'h0, bus.stall_req_mem_o}, {31'h0, bus.mem_req_i && !e_memd});
            if (k == dk) begin
                if (is_if)    exp_if_data  = rd;
                else if (!wr) exp_mem_data = rd;
                if (is_if) bus.if_req_i = 1'b0;
                else       bus.mem_req_i = 1'b0;
                bus.flush_i = 1'b0;
            end
            check("if_data",   bus.if_data_o,   exp_if_data);
            check("mem_rdata", bus.mem_rdata_o, exp_mem_data);
            // A flush during a data access must have no effect.
            if (!is_if && k < dk) bus.flush_i = ($urandom_range(0, 3) == 0);
        end
        exp_last_addr = addr + 32'(n - 1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) set_byte(12'(i), 8'($urandom));
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = 32'h0;
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_width_i = 2'd0;
        bus.mem_addr_i  = 32'h0;
        bus.mem_wdata_i = 32'h0;
        bus.flush_i     = 1'b0;

        // reset state
        #1 rst = 1'b0;
        #20;
        check("rst_addr",     bus.ram_addr_o,  32'h0);
        check("rst_we",       {31'h0, bus.ram_we_o},   32'h0);
        check("rst_wdata",    {24'h0, bus.ram_wdata_o}, 32'h0);
        check("rst_if_data",  bus.if_data_o,   32'h0);
        check("rst_mem_data", bus.mem_rdata_o, 32'h0);
        check("rst_if_done",  {31'h0, bus.if_done_o},  32'h0);
        check("rst_mem_done", {31'h0, bus.mem_done_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // word fetch at 0x10
        set_byte(12'h010, 8'h13);
        set_byte(12'h011, 8'h05);
        set_byte(12'h012, 8'h10);
        set_byte(12'h013, 8'h00);
        run_txn(1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
        check("fetch_word", bus.if_data_o, 32'h00100513);
        idle(2);

        // simultaneous requests: MEM first, IF right after the blocked done cycle
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h20;
        run_txn(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        idle(1);
        run_txn(1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
        idle(1);

        // byte store, then read the word back
        run_txn(1'b0, 1'b1, 2'd0, 32'h103, 32'h123456AB);
        idle(1);
        run_txn(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        check("store_byte_readback", {24'h0, bus.mem_rdata_o[31:24]}, 32'hAB);
        idle(1);

        // half load at 0x200
        set_byte(12'h200, 8'h34);
        set_byte(12'h201, 8'h12);
        run_txn(1'b0, 1'b0, 2'd1, 32'h200, 32'h0);
        check("half_load", bus.mem_rdata_o, 32'h00001234);
        idle(1);

        // flush in A+2 of a fetch at 0x40, redirect to 0x80
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h40;
        @(negedge clk);
        check("flush_addr0", bus.ram_addr_o, 32'h40);
        @(negedge clk);
        check("flush_addr1", bus.ram_addr_o, 32'h41);
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush_no_done", {31'h0, bus.if_done_o}, 32'h0);
        check("flush_data",    bus.if_data_o, exp_if_data);
        bus.flush_i = 1'b0;
        run_txn(1'b1, 1'b0, 2'd2, 32'h80, 32'h0);
        idle(2);

        // reset during A+2 of a word store at 0x300
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_width_i = 2'd2;
        bus.mem_addr_i  = 32'h300;
        bus.mem_wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        check("rstmid_addr0", bus.ram_addr_o, 32'h300);
        check("rstmid_we0",   {31'h0, bus.ram_we_o}, 32'h1);
        @(negedge clk);
        check("rstmid_we1",   {31'h0, bus.ram_we_o}, 32'h1);
        #1 rst = 1'b0;
        #1;
        check("rstmid_we",       {31'h0, bus.ram_we_o},   32'h0);
        check("rstmid_if_done",  {31'h0, bus.if_done_o},  32'h0);
        check("rstmid_mem_done", {31'h0, bus.mem_done_o}, 32'h0);
        check("rstmid_if_data",  bus.if_data_o,   32'h0);
        check("rstmid_mem_data", bus.mem_rdata_o, 32'h0);
        bus.mem_req_i = 1'b0;
        bus.mem_we_i  = 1'b0;
        shadow[12'h300] = 8'h0D;
        exp_if_data   = 32'h0;
        exp_mem_data  = 32'h0;
        exp_last_addr = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(2);
        run_txn(1'b0, 1'b0, 2'd2, 32'h300, 32'h0);
        idle(1);

        // randomized mix
        for (int t = 0; t < 80; t++) begin
            run_txn($urandom_range(0, 2) == 0, 1'($urandom), 2'($urandom),
                    32'($urandom_range(0, 4000)), $urandom);
            idle($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Schedules the CPU's single byte-wide RAM port between two requesters: instruction fetch (IF, driven by the PC register) and the data-access stage (MEM, loads and stores).
- Assembles and disassembles 32-bit little-endian words over multiple cycles.
- Raises per-stage stall requests to the pipeline controller, which drives the stall[5:0] vector.
- Aborts an in-flight fetch when a branch redirect occurs.

Parameters:
ADDR_W, 32, width of requester and RAM addresses

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-low reset
if_req_i  input  1  fetch request; held until if_done_o
if_addr_i  input  ADDR_W  fetch address (word access)
if_data_o  output  32  fetched instruction, valid with if_done_o
if_done_o  output  1  one-cycle fetch completion pulse
mem_req_i  input  1  data request; held until mem_done_o
mem_we_i  input  1  1 = store, 0 = load
mem_width_i  input  2  0 = byte, 1 = half, 2 = word (3 treated as word)
mem_addr_i  input  ADDR_W  data address
mem_wdata_i  input  32  store data; low bytes used for byte/half
mem_rdata_o  output  32  load data, zero-extended, valid with mem_done_o
mem_done_o  output  1  one-cycle data completion pulse
flush_i  input  1  branch redirect (EX or ID); kills the current fetch
ram_addr_o  output  ADDR_W  RAM byte address
ram_we_o  output  1  RAM write enable
ram_wdata_o  output  8  RAM write byte
ram_rdata_i  input  8  RAM read byte; synchronous, valid the cycle after the address
stall_req_if_o  output  1  if_req_i & ~if_done_o (combinational)
stall_req_mem_o  output  1  mem_req_i & ~mem_done_o (combinational)

Behaviour:
- Reset (rst low, asynchronous): state IDLE, byte counter 0. All registered outputs are 0: if_data_o, mem_rdata_o, done pulses, ram_addr_o, ram_we_o and ram_wdata_o.
- Reset asserted mid-transaction aborts it with no done pulse; ram_we_o drops immediately.
- States: IDLE, BUSY_IF, BUSY_MEM.
- Acceptance:
  - Acceptance is evaluated in IDLE only, and never in a cycle where either done output is high. This prevents re-accepting a held request.
  - Priority: MEM over IF, because MEM belongs to the older instruction.
  - An IF request seen together with flush_i is not accepted that cycle.
  - Address, width, we and wdata are latched at acceptance.
- Byte count n: byte = 1, half = 2, word = 4. IF is always 4.
- Timing, with A = the acceptance cycle:
  - Cycles A+1..A+n: ram_addr_o = base + k for k = 0..n-1. ADDR_W wrap-around is permitted and not checked.
  - Alignment is not checked.
- Read timing:
  - The byte addressed in cycle c is captured from ram_rdata_i at the end of cycle c+1, into bits [8k+7:8k].
  - Done pulse and data appear in cycle A+n+2. The state returns to IDLE in that same cycle.
  - Unfilled upper bytes are 0.
- Write timing:
  - ram_we_o is high in cycles A+1..A+n.
  - ram_wdata_o = mem_wdata_i byte k during those cycles.
  - mem_done_o pulses in cycle A+n+1, and the state returns to IDLE.
- Data output hold: if_data_o and mem_rdata_o keep their value until the next completion of the same requester.
- ram_addr_o in IDLE: holds its last value, with ram_we_o = 0.
- Flush:
  - flush_i in BUSY_IF: the fetch aborts and the state is IDLE in the next cycle.
  - No if_done_o is produced and if_data_o is unchanged.
  - The redirected fetch restarts at byte 0.
  - flush_i has no effect in BUSY_MEM or IDLE, apart from the acceptance rule above.
- Done pulses: each is exactly one cycle. if_done_o and mem_done_o are never high together.

Test Plan:
- IF fetch at 0x00000010, RAM bytes 0x13, 0x05, 0x10, 0x00 -> ram_addr_o = 0x10..0x13 in A+1..A+4; if_done_o in A+6 only; if_data_o = 0x00100513; stall_req_if_o high from A until A+6, then low.
- if_req_i and mem_req_i (word load at 0x100) raised in the same cycle -> MEM is served first; IF is accepted in the cycle after mem_done_o; no overlapping RAM addresses.
- Store byte 0xAB at 0x103 (mem_width_i = 0, mem_wdata_i = 0x123456AB) -> one cycle with ram_we_o = 1, ram_addr_o = 0x103, ram_wdata_o = 0xAB; mem_done_o in A+2.
- Half load at 0x200, bytes 0x34, 0x12 -> mem_rdata_o = 0x00001234 with mem_done_o in A+4.
- flush_i pulsed in A+2 of a fetch at 0x40, then if_addr_i = 0x80 -> no if_done_o for 0x40; a new fetch is accepted; ram_addr_o restarts at 0x80.
- rst driven low during A+2 of a word store -> ram_we_o and all done/data outputs go 0 without a clock edge; after release the state is IDLE and a new request is accepted normally.
